priority_decoder_2to4_seq: RTL and testbench

Sequential 2-to-4 decoder that expands (Y, V) codes from the 4-to-2 priority encoder back into a one-hot D[3:0] line. Codes arrive over a valid/ready handshake. Each accepted valid code drives its one-hot line for a fixed number of cycles, followed by an optional quiet gap. The block sits on the receive side of an encoded request bus and restores per-line strobes for downstream logic. It also counts decoded events.

---
 rtl/priority_decoder_2to4_seq.sv | 144 ++++++++++++++
 tb/tb_priority_decoder_2to4_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_decoder_2to4_seq.sv
// Purpose: expands (Y, V) priority-encoder codes into a registered one-hot D strobe and counts decoded events.
// Latency: D rises the cycle after acceptance, stays high HOLD cycles, then GAP quiet cycles before the next accept.
// Backpressure: in_ready is low throughout HOLD and GAP; codes offered then are not consumed and are not stored.
module priority_decoder_2to4_seq #(
    parameter int HOLD = 4,
    parameter int GAP  = 1,
    parameter int CW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    Y,
    input  logic          V,
    output logic [3:0]    D,
    output logic          busy,
    output logic          no_code,
    output logic [CW-1:0] code_count
);

    // The counter is reused for both the HOLD and GAP phases, so it is sized for the longer of the two.
    localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int GAP_M1  = (GAP > 0) ? (GAP - 1) : 0;

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_M1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       y_lat;
    logic [3:0]       d_nxt;
    logic             accept;
    logic             accept_code;
    logic             accept_none;
    logic             cnt_zero;

    assign accept      = in_valid && (state == ST_IDLE);
    assign accept_code = accept && V;
    assign accept_none = accept && !V;
    assign cnt_zero    = (cnt == '0);

    // State register; reset lands in IDLE immediately so in_ready comes back without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a V=1 accept starts HOLD; HOLD and GAP each run until the counter hits zero.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept_code) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_zero) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Phase counter next value: load HOLD-1 on accept, GAP-1 on leaving HOLD, otherwise count down to zero.
    always_comb begin
        cnt_nxt = cnt;
        case (state)
            ST_IDLE: begin
                if (accept_code) begin
                    cnt_nxt = HOLD_LD;
                end
            end
            ST_HOLD: begin
                cnt_nxt = cnt_zero ? GAP_LD : (cnt - CNT_W'(1));
            end
            ST_GAP: begin
                if (!cnt_zero) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: cnt_nxt = '0;
        endcase
    end

    // Phase counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Output decode: D's next value is one-hot only while HOLD continues, so it can never be multi-hot.
    always_comb begin
        d_nxt    = 4'b0000;
        in_ready = (state == ST_IDLE);
        busy     = (state != ST_IDLE);
        if (accept_code) begin
            d_nxt = 4'b0001 << Y;
        end else if ((state == ST_HOLD) && !cnt_zero) begin
            d_nxt = 4'b0001 << y_lat;
        end
    end

    // Registered outputs; the latched Y keeps D stable while new codes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D          <= 4'b0000;
            y_lat      <= 2'b00;
            no_code    <= 1'b0;
            code_count <= '0;
        end else begin
            D       <= d_nxt;
            no_code <= accept_none;
            if (accept_code) begin
                y_lat <= Y;
                if (code_count != {CW{1'b1}}) begin
                    code_count <= code_count + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_priority_decoder_2to4_seq.sv
// Purpose: scoreboard bench for two decoder configurations (HOLD=4/GAP=1/CW=8 and HOLD=1/GAP=0/CW=2).
// Latency: expected D rises are queued at acceptance and popped when the DUT raises D.
// Backpressure: the reference decides readiness from its own timing and checks in_ready against it.
module tb_priority_decoder_2to4_seq;

    localparam int HOLD_A = 4;
    localparam int GAP_A  = 1;
    localparam int CW_A   = 8;
    localparam int HOLD_B = 1;
    localparam int GAP_B  = 0;
    localparam int CW_B   = 2;

    typedef struct {
        int d;
        int cnt;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic            vld_a = 1'b0;
    logic [1:0]      y_a = 2'b00;
    logic            v_a = 1'b0;
    logic            rdy_a;
    logic [3:0]      d_a;
    logic            busy_a;
    logic            no_code_a;
    logic [CW_A-1:0] cc_a;

    logic            vld_b = 1'b0;
    logic [1:0]      y_b = 2'b00;
    logic            v_b = 1'b0;
    logic            rdy_b;
    logic [3:0]      d_b;
    logic            busy_b;
    logic            no_code_b;
    logic [CW_B-1:0] cc_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int hold_p[2] = '{HOLD_A, HOLD_B};
    int gap_p[2]  = '{GAP_A, GAP_B};
    int cmax[2]   = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
    int free_at[2] = '{0, 0};
    int cnt_m[2]   = '{0, 0};
    int prev_d[2]  = '{0, 0};
    int run[2]     = '{0, 0};

    exp_t q_a[$];
    exp_t q_b[$];
    int   ncq_a[$];
    int   ncq_b[$];

    always #5 clk = ~clk;

    priority_decoder_2to4_seq #(.HOLD(HOLD_A), .GAP(GAP_A), .CW(CW_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(vld_a), .in_ready(rdy_a), .Y(y_a), .V(v_a),
        .D(d_a), .busy(busy_a), .no_code(no_code_a), .code_count(cc_a)
    );

    priority_decoder_2to4_seq #(.HOLD(HOLD_B), .GAP(GAP_B), .CW(CW_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vld_b), .in_ready(rdy_b), .Y(y_b), .V(v_b),
        .D(d_b), .busy(busy_b), .no_code(no_code_b), .code_count(cc_b)
    );

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference: a code is taken when the block has been free since free_at; a V=1 code
    // occupies HOLD+GAP cycles after the acceptance edge.
    task automatic model_step(input int k, input logic iv, input logic [1:0] y, input logic v);
        exp_t e;
        if (iv && (cyc >= free_at[k])) begin
            if (v) begin
                if (cnt_m[k] < cmax[k]) cnt_m[k]++;
                e.d   = 1 << y;
                e.cnt = cnt_m[k];
                e.cyc = cyc + 1;
                if (k == 0) q_a.push_back(e); else q_b.push_back(e);
                free_at[k] = cyc + 1 + hold_p[k] + gap_p[k];
            end else begin
                if (k == 0) ncq_a.push_back(cyc + 1); else ncq_b.push_back(cyc + 1);
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_at = '{0, 0};
            cnt_m   = '{0, 0};
            q_a.delete();
            q_b.delete();
            ncq_a.delete();
            ncq_b.delete();
        end else begin
            model_step(0, vld_a, y_a, v_a);
            model_step(1, vld_b, y_b, v_b);
            cyc++;
        end
    end

    task automatic mon_step(input int k, input logic [3:0] d, input int cc, input logic nc,
                            input logic rdy, input logic bsy);
        exp_t  e;
        int    nc_cyc;
        bit    have;
        string nm;
        nm = (k == 0) ? "A" : "B";
        check({nm, " in_ready"}, int'(rdy), int'(cyc >= free_at[k]));
        check({nm, " busy"}, int'(bsy), int'(cyc < free_at[k]));
        check({nm, " code_count"}, cc, cnt_m[k]);
        if (d != 4'b0000) check({nm, " d_onehot"}, $countones(d), 1);
        if ((d != 4'b0000) && (prev_d[k] == 0)) begin
            have = (k == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
            if (!have) begin
                check({nm, " unexpected_d_rise"}, int'(d), 0);
            end else begin
                e = (k == 0) ? q_a.pop_front() : q_b.pop_front();
                check({nm, " d_value"}, int'(d), e.d);
                check({nm, " d_rise_cycle"}, cyc, e.cyc);
                check({nm, " count_at_rise"}, cc, e.cnt);
            end
            run[k] = 1;
        end else if (d != 4'b0000) begin
            check({nm, " d_stable"}, int'(d), prev_d[k]);
            run[k]++;
        end else if (prev_d[k] != 0) begin
            check({nm, " d_hold_len"}, run[k], hold_p[k]);
            run[k] = 0;
        end
        prev_d[k] = int'(d);
        if (nc) begin
            have = (k == 0) ? (ncq_a.size() > 0) : (ncq_b.size() > 0);
            if (!have) begin
                check({nm, " unexpected_no_code"}, 1, 0);
            end else begin
                nc_cyc = (k == 0) ? ncq_a.pop_front() : ncq_b.pop_front();
                check({nm, " no_code_cycle"}, cyc, nc_cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_d = '{0, 0};
            run    = '{0, 0};
        end else begin
            mon_step(0, d_a, int'(cc_a), no_code_a, rdy_a, busy_a);
            mon_step(1, d_b, int'(cc_b), no_code_b, rdy_b, busy_b);
        end
    end

    // Offer one code on A and return just after the edge that accepts it.
    task automatic send_a(input logic [1:0] y, input logic v, input bit keep);
        int n;
        n = 0;
        @(negedge clk);
        y_a   = y;
        v_a   = v;
        vld_a = 1'b1;
        while (!rdy_a && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("A accept_timeout", n, 0);
        @(posedge clk);
        #1;
        if (!keep) vld_a = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " D_a"}, int'(d_a), 0);
        check({tag, " busy_a"}, int'(busy_a), 0);
        check({tag, " count_a"}, int'(cc_a), 0);
        check({tag, " ready_a"}, int'(rdy_a), 1);
        check({tag, " no_code_a"}, int'(no_code_a), 0);
        check({tag, " D_b"}, int'(d_b), 0);
        check({tag, " count_b"}, int'(cc_b), 0);
        check({tag, " ready_b"}, int'(rdy_b), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state("por");
        #2 rst_n = 1'b1;

        // Reset in the middle of HOLD clears everything without waiting for a clock.
        send_a(2'b10, 1'b1, 1'b0);
        @(negedge clk);
        check("pre_reset D_a", int'(d_a), 4);
        #2 rst_n = 1'b0;
        #1 check_reset_state("mid_hold_reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        send_a(2'b01, 1'b1, 1'b0);
        check("post_reset D_a", int'(d_a), 2);

        // All four codes with in_valid kept high between them.
        for (int i = 0; i < 4; i++) send_a(2'(i), 1'b1, 1'b1);
        send_a(2'b11, 1'b0, 1'b0);

        // Y changes while busy are ignored; the new code is taken only after the quiet gap.
        send_a(2'b10, 1'b1, 1'b1);
        y_a = 2'b01;
        send_a(2'b01, 1'b1, 1'b0);

        // Back-to-back on B with alternating codes; the 2-bit counter saturates.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vld_b = 1'b1;
            v_b   = 1'b1;
            y_b   = (i % 2 == 0) ? 2'b00 : 2'b11;
        end
        @(negedge clk);
        vld_b = 1'b0;

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            vld_a = 1'($urandom_range(0, 1));
            y_a   = 2'($urandom);
            v_a   = ($urandom_range(0, 3) != 0);
            vld_b = 1'($urandom_range(0, 1));
            y_b   = 2'($urandom);
            v_b   = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        vld_a = 1'b0;
        vld_b = 1'b0;
        repeat (12) @(negedge clk);

        check("A pending_codes", q_a.size(), 0);
        check("B pending_codes", q_b.size(), 0);
        check("A pending_no_code", ncq_a.size(), 0);
        check("B pending_no_code", ncq_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
